// File: rtl/vga_example.sv
// vga_example: 640x480@60 Hz VGA demo core for a TinyTapeout tile.
// Generates sync timing from a 25.175 MHz pixel clock and drives a TinyVGA
// PMOD (2 bits per colour) with either an animated test pattern or a solid
// colour taken from ui_in.
//
// Ports:
//   clk      in   pixel clock
//   rst_n    in   asynchronous active-low reset
//   ena      in   tile enable (ignored)
//   ui_in    in   [0] pause frame counter, [1] mode (0 pattern, 1 solid),
//                 [7:6] solid R, [5:4] solid G, [3:2] solid B
//   uio_in   in   unused
//   uo_out   out  {hsync, B0, G0, R0, vsync, B1, G1, R1}, registered
//   uio_out  out  constant 0
//   uio_oe   out  constant 0 (all bidirectional pins are inputs)

module vga_example (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [9:0] H_LAST       = 10'd799;
    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd751;
    localparam logic [9:0] V_LAST       = 10'd524;
    localparam logic [9:0] V_VISIBLE    = 10'd480;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd491;

    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] f;

    logic       hsync;
    logic       vsync;
    logic       visible;
    logic [9:0] xs;
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
    logic [7:0] pixel;

    // ena and uio_in are deliberately ignored.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in};

    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    assign hsync   = !((x >= H_SYNC_START) && (x <= H_SYNC_END));
    assign vsync   = !((y >= V_SYNC_START) && (y <= V_SYNC_END));
    assign visible = (x < H_VISIBLE) && (y < V_VISIBLE);

    // Horizontal scroll: the pattern slides left by one pixel per frame.
    assign xs = x + f;

    always_comb begin
        r = 2'b00;
        g = 2'b00;
        b = 2'b00;
        if (visible) begin
            if (ui_in[1]) begin
                r = ui_in[7:6];
                g = ui_in[5:4];
                b = ui_in[3:2];
            end else begin
                r = xs[7:6];
                g = y[7:6];
                b = (xs[5] ^ y[5]) ? 2'b11 : 2'b00;
            end
        end
    end

    // TinyVGA PMOD pin order: MSBs with vsync on the low nibble,
    // LSBs with hsync on the high nibble.
    assign pixel = {hsync, b[0], g[0], r[0], vsync, b[1], g[1], r[1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x      <= 10'd0;
            y      <= 10'd0;
            f      <= 10'd0;
            uo_out <= 8'h88;
        end else begin
            // Output is one cycle behind the counters; sync and colour
            // come from the same pixel so they stay aligned.
            uo_out <= pixel;
            if (x == H_LAST) begin
                x <= 10'd0;
                if (y == V_LAST) begin
                    y <= 10'd0;
                    if (!ui_in[0]) begin
                        f <= f + 10'd1;
                    end
                end else begin
                    y <= y + 10'd1;
                end
            end else begin
                x <= x + 10'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_example.sv
module tb_vga_example;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_total;
    int n_pass;
    int n_fail;

    vga_example dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and sample just after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ui(input logic [7:0] v);
        @(negedge clk);
        ui_in = v;
    endtask

    // Place the counters at (jx, jy) between edges; the next edge then
    // presents pixel (jx, jy) on uo_out. Keeps the run far below a frame.
    task automatic jump(input logic [9:0] jx, input logic [9:0] jy);
        @(negedge clk);
        force dut.x = jx;
        force dut.y = jy;
        release dut.x;
        release dut.y;
        tick(1);
    endtask

    initial begin
        int cnt;
        int first;
        logic [7:0] v490;

        n_total = 0;
        n_pass  = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        ena     = 1'b1;
        ui_in   = 8'h00;
        uio_in  = 8'h00;

        #100;
        check("reset_uo_out", {24'd0, uo_out}, 32'h88);
        check("reset_uio_out", {24'd0, uio_out}, 32'h00);
        check("reset_uio_oe", {24'd0, uio_oe}, 32'h00);

        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        check("px_0_0_f0", {24'd0, uo_out}, 32'h88);
        tick(32);
        check("px_32_0_f0", {24'd0, uo_out}, 32'hCC);
        tick(32);
        check("px_64_0_f0", {24'd0, uo_out}, 32'h98);
        tick(576);
        check("px_640_0_blank", {24'd0, uo_out}, 32'h88);
        tick(15);
        check("px_655_0_hsync_high", {24'd0, uo_out}, 32'h88);
        tick(1);
        check("px_656_0_hsync_low", {24'd0, uo_out}, 32'h08);
        tick(95);
        check("px_751_0_hsync_low", {24'd0, uo_out}, 32'h08);
        tick(1);
        check("px_752_0_hsync_high", {24'd0, uo_out}, 32'h88);
        tick(47);
        check("px_799_0", {24'd0, uo_out}, 32'h88);

        // Line 1: hsync low width and position; ena/uio_in must not matter.
        cnt   = 0;
        first = -1;
        for (int i = 0; i < 800; i++) begin
            ena    = $urandom_range(0, 1);
            uio_in = 8'($urandom);
            tick(1);
            if (uo_out[7] == 1'b0) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        check("hsync_first_low_line1", first, 656);
        check("hsync_low_width", cnt, 96);
        ena    = 1'b1;
        uio_in = 8'h00;

        jump(10'd0, 10'd64);
        check("px_0_64_green", {24'd0, uo_out}, 32'hA8);
        jump(10'd0, 10'd96);
        check("px_0_96_green_blue", {24'd0, uo_out}, 32'hEC);

        // Vertical sync over lines 489..491.
        jump(10'd0, 10'd489);
        cnt   = 0;
        first = -1;
        v490  = 8'h00;
        for (int i = 1; i < 2400; i++) begin
            tick(1);
            if (i == 800) v490 = uo_out;
            if (uo_out[3] == 1'b0) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        check("vsync_first_low", first, 800);
        check("vsync_low_width", cnt, 1600);
        check("px_0_490", {24'd0, v490}, 32'h80);

        // Pause held over two frame boundaries: f stays 0.
        set_ui(8'h01);
        jump(10'd795, 10'd524);
        tick(68);
        check("pause_frame_a_px_63_0", {24'd0, uo_out}, 32'hCC);
        jump(10'd795, 10'd524);
        tick(68);
        check("pause_frame_b_px_63_0", {24'd0, uo_out}, 32'hCC);

        // Pause released: next boundary advances f to 1.
        set_ui(8'h00);
        jump(10'd795, 10'd524);
        tick(5);
        check("f1_px_0_0", {24'd0, uo_out}, 32'h88);
        tick(31);
        check("f1_px_31_0", {24'd0, uo_out}, 32'hCC);
        tick(32);
        check("f1_px_63_0", {24'd0, uo_out}, 32'h98);

        // Solid colour.
        set_ui(8'hFE);
        jump(10'd100, 10'd200);
        check("solid_visible", {24'd0, uo_out}, 32'hFF);
        tick(540);
        check("solid_px_640_blank", {24'd0, uo_out}, 32'h88);
        tick(60);
        check("solid_px_700_hsync", {24'd0, uo_out}, 32'h08);
        set_ui(8'h9E);
        jump(10'd100, 10'd200);
        check("solid_9e_visible", {24'd0, uo_out}, 32'hED);
        set_ui(8'hFE);
        jump(10'd100, 10'd490);
        check("solid_vsync_blank", {24'd0, uo_out}, 32'h80);
        jump(10'd700, 10'd490);
        check("solid_both_sync", {24'd0, uo_out}, 32'h00);
        jump(10'd100, 10'd200);
        check("solid_visible_again", {24'd0, uo_out}, 32'hFF);

        // Mid-frame reset: immediate 0x88, then restart from (0,0).
        #5;
        rst_n = 1'b0;
        #1;
        check("midframe_reset_uo", {24'd0, uo_out}, 32'h88);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        check("after_reset_px_0_0", {24'd0, uo_out}, 32'hFF);
        tick(640);
        check("after_reset_px_640_0", {24'd0, uo_out}, 32'h88);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vga_example.md
# vga_example

Self-contained VGA demo core for a TinyTapeout tile. It generates 640x480 at 60 Hz timing from a 25.175 MHz pixel clock and drives a TinyVGA PMOD with 2 bits per colour plus sync on the dedicated outputs. The picture is either an animated test pattern or a solid colour selected from the inputs. The block is the user-project top level; the bidirectional pins are unused.

## Interface
- No parameters. Timing constants are fixed as listed under Timing.
- `clk` in 1: pixel clock, 25.175 MHz nominal. All state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: tile enable. Ignored.
- `ui_in` in 8:
  - [0] pause: 1 = freeze the frame counter.
  - [1] mode: 0 = pattern, 1 = solid colour.
  - [7:6] solid red, [5:4] solid green, [3:2] solid blue.
- `uio_in` in 8: unused.
- `uo_out` out 8:
  - [0] R1, [1] G1, [2] B1, [3] vsync.
  - [4] R0, [5] G0, [6] B0, [7] hsync.
  - Bit 1 of each colour is the MSB.
- `uio_out` out 8: constant 0.
- `uio_oe` out 8: constant 0 (all inputs).

## Operation
- **Horizontal counter `x`** (10 bit):
  - Counts 0..799, then wraps to 0.
- **Vertical counter `y`** (10 bit):
  - Increments when `x` wraps.
  - Counts 0..524, then wraps to 0.
- **Frame counter `f`** (10 bit):
  - Increments when x=799 and y=524, unless `ui_in[0]`=1.
  - Wraps mod 1024.
- **hsync**: low when 656 ≤ x ≤ 751, otherwise high.
- **vsync**: low when 490 ≤ y ≤ 491, otherwise high.
- **visible**: x < 640 and y < 480.
- **Pattern mode** (`ui_in[1]`=0), with xs = (x + f) mod 1024:
  - R = xs[7:6].
  - G = y[7:6].
  - B = 2'b11 if xs[5] XOR y[5], else 2'b00.
- **Solid mode** (`ui_in[1]`=1): R = ui_in[7:6], G = ui_in[5:4], B = ui_in[3:2].
- **Blanking**: when not visible, RGB = 0 in both modes. Sync outputs still follow the counters.
- `ui_in` is sampled every cycle with no synchroniser. A change takes effect on the next output register update.
- `ena`, `uio_in` have no effect.

## Timing
- **Horizontal line**: 800 clocks.
  - 640 visible, 16 front porch, 96 sync, 48 back porch.
- **Vertical frame**: 525 lines.
  - 480 visible, 10 front porch, 2 sync, 33 back porch.
  - Frame = 420 000 clocks.
- **Output register**: the value on `uo_out` during cycle n+1 encodes the pixel (x, y, f) that was current in cycle n.
  - Sync and colour are aligned to each other.
- **Reset** (asynchronous, rst_n=0):
  - x=0, y=0, f=0.
  - `uo_out`=0x88: syncs inactive high, RGB 0.
  - `uio_out`=0, `uio_oe`=0.
- **After rst_n rises**: the first rising edge loads `uo_out` with pixel (0,0) and advances x to 1.
- **Reset asserted mid-frame**: outputs return to 0x88 immediately. Timing restarts from (0,0) after release.
- **Pause**: asserting pause at the frame boundary holds f. Releasing it resumes counting at the next boundary.
- **Wraps**:
  - x=799→0 and y=524→0 occur on the same edge.
  - f=1023→0 is silent.

## Test plan
- **Reset**: hold rst_n=0 with ui_in=0 → `uo_out`=0x88, `uio_out`=0x00, `uio_oe`=0x00.
- **hsync**: release reset with ui_in=0.
  - hsync (bit 7) first goes low after edge 657.
  - It stays low exactly 96 clocks.
  - Falling edges repeat every 800 clocks.
- **vsync**: vsync (bit 3) goes low for exactly 1600 clocks.
  - Falling edges repeat every 420 000 clocks.
  - The first falling edge comes after 490×800+1 edges.
- **Pattern, frame 0**:
  - Pixel (0,0) → `uo_out`=0x88.
  - Pixel (64,0) → 0x98 (R0=1).
  - Pixel (32,0) → 0xCC (B=11, xs[5]=1).
  - Pixel (640,0) → RGB 0, hsync high → 0x88.
- **Solid mode**: ui_in=0xFE.
  - Visible pixels → `uo_out`=0xFF, except during sync.
  - Blanking pixels → 0x88, or with the corresponding sync bit cleared during sync.
- **Animation and pause**:
  - With ui_in=0, pixel (0,0) of frame 1 (f=1) → xs=1 → 0x88.
  - Pixel (63,0) of frame 1 → xs=64 → 0x98.
  - With ui_in=0x01 held over two frames, pixel (63,0) stays 0xCC (f frozen at 0).
